// File: rtl/key_scan_arbiter.sv
// Round-robin debouncer: one settle counter is time-shared between KEY_NUM active-low keys.
// Optional release pulse output is enabled by defining KEY_RELEASE_FLAG_EN.
module key_scan_arbiter #(
  parameter int                 KEY_NUM = 4,
  parameter int                 CNT_W   = 20,
  parameter logic [CNT_W-1:0]   CNT_MAX = 20'd999_999
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [KEY_NUM-1:0]    key_in,
  output logic [KEY_NUM-1:0]    key_state,
  output logic [KEY_NUM-1:0]    key_flag,
  output logic [KEY_NUM-1:0]    key_release,
  output logic [((KEY_NUM > 1) ? $clog2(KEY_NUM) : 1)-1:0] grant_idx,
  output logic                  busy
);

  localparam int GW = (KEY_NUM > 1) ? $clog2(KEY_NUM) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  state_e               state_q;
  logic [KEY_NUM-1:0]   sync1_q;
  logic [KEY_NUM-1:0]   sync2_q;
  logic [KEY_NUM-1:0]   key_state_q;
  logic [KEY_NUM-1:0]   key_flag_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [GW-1:0]        ptr_q;
  logic [GW-1:0]        grant_q;
  logic                 busy_q;
  logic [KEY_NUM-1:0]   mismatch_s;
  logic [GW-1:0]        pick_s;
`ifdef KEY_RELEASE_FLAG_EN
  logic [KEY_NUM-1:0]   key_release_q;
`endif

  function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] idx);
    if (int'(idx) >= KEY_NUM - 1) begin
      return '0;
    end else begin
      return idx + GW'(1);
    end
  endfunction

  // Two-flop synchroniser; idle level of an active-low key is 1
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  assign mismatch_s = sync2_q ^ key_state_q;

  // Walking from the far end back to ptr leaves the first hit in search order
  always_comb begin
    pick_s = '0;
    for (int i = KEY_NUM - 1; i >= 0; i--) begin
      if (mismatch_s[GW'((int'(ptr_q) + i) % KEY_NUM)]) begin
        pick_s = GW'((int'(ptr_q) + i) % KEY_NUM);
      end else begin
        pick_s = pick_s;
      end
    end
  end

  // Arbitration, settle counting and commit of the debounced level
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      key_state_q <= '1;
      key_flag_q  <= '0;
`ifdef KEY_RELEASE_FLAG_EN
      key_release_q <= '0;
`endif
    end else begin
      key_flag_q <= '0;
`ifdef KEY_RELEASE_FLAG_EN
      key_release_q <= '0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (|mismatch_s) begin
            grant_q <= pick_s;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          // A bounce back hands the counter to the next key in line
          if (!mismatch_s[grant_q]) begin
            ptr_q   <= wrap_inc(grant_q);
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= ST_COMMIT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_COMMIT: begin
          key_state_q[grant_q] <= ~key_state_q[grant_q];
          if (key_state_q[grant_q]) begin
            key_flag_q[grant_q] <= 1'b1;
          end
`ifdef KEY_RELEASE_FLAG_EN
          else begin
            key_release_q[grant_q] <= 1'b1;
          end
`endif
          ptr_q   <= wrap_inc(grant_q);
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign key_state = key_state_q;
  assign key_flag  = key_flag_q;
  assign grant_idx = grant_q;
  assign busy      = busy_q;
`ifdef KEY_RELEASE_FLAG_EN
  assign key_release = key_release_q;
`else
  assign key_release = '0;
`endif

endmodule

// File: tb/tb_key_scan_arbiter.sv
// Directed bench for key_scan_arbiter with KEY_NUM=4, CNT_MAX=24.
module tb_key_scan_arbiter;

  logic       sys_clk;
  logic       sys_rst;
  logic [3:0] key_in;
  logic [3:0] key_state;
  logic [3:0] key_flag;
  logic [3:0] key_release;
  logic [1:0] grant_idx;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;

`ifdef KEY_RELEASE_FLAG_EN
  localparam logic [3:0] REL_EXP = 4'b0001;
`else
  localparam logic [3:0] REL_EXP = 4'b0000;
`endif

  key_scan_arbiter #(
    .KEY_NUM (4),
    .CNT_W   (20),
    .CNT_MAX (20'd24)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .key_in      (key_in),
    .key_state   (key_state),
    .key_flag    (key_flag),
    .key_release (key_release),
    .grant_idx   (grant_idx),
    .busy        (busy)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  typedef struct {
    logic       do_rst;
    logic [3:0] key;
    int         edges;
    logic [3:0] st;
    logic [3:0] fl;
    logic [3:0] rl;
    logic       bz;
    logic [1:0] gr;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    key_in  = 4'b1111;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  // Press and release pulses are exclusive across both vectors
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      chk("pulse_onehot", 32'($countones({key_flag, key_release}) <= 1), 32'd1);
      if (|{key_flag, key_release}) pulse_cnt++;
    end
  end

  initial begin
    sys_rst = 1'b1;
    key_in  = 4'b1111;

    // clean press then release of key 0, ptr starts at 0
    vt.push_back('{1'b0, 4'b1110,  2, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0});
    vt.push_back('{1'b0, 4'b1110,  1, 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd0});
    vt.push_back('{1'b0, 4'b1110, 25, 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd0});
    vt.push_back('{1'b0, 4'b1110,  1, 4'b1110, 4'b0001, 4'b0000, 1'b0, 2'd0});
    vt.push_back('{1'b0, 4'b1110,  1, 4'b1110, 4'b0000, 4'b0000, 1'b0, 2'd0});
    vt.push_back('{1'b0, 4'b1111, 28, 4'b1110, 4'b0000, 4'b0000, 1'b1, 2'd0});
    vt.push_back('{1'b0, 4'b1111,  1, 4'b1111, 4'b0000, REL_EXP, 1'b0, 2'd0});
    vt.push_back('{1'b0, 4'b1111,  1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0});
    // simultaneous press of keys 0 and 2: flags 27 cycles apart
    vt.push_back('{1'b1, 4'b1010, 28, 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd0});
    vt.push_back('{1'b0, 4'b1010,  1, 4'b1110, 4'b0001, 4'b0000, 1'b0, 2'd0});
    vt.push_back('{1'b0, 4'b1010,  1, 4'b1110, 4'b0000, 4'b0000, 1'b1, 2'd2});
    vt.push_back('{1'b0, 4'b1010, 25, 4'b1110, 4'b0000, 4'b0000, 1'b1, 2'd2});
    vt.push_back('{1'b0, 4'b1010,  1, 4'b1010, 4'b0100, 4'b0000, 1'b0, 2'd2});
    vt.push_back('{1'b0, 4'b1010,  1, 4'b1010, 4'b0000, 4'b0000, 1'b0, 2'd2});
    // ptr left at 3 by key 2, then keys 0 and 3 together: 3 first, then wrap to 0
    vt.push_back('{1'b1, 4'b1011, 29, 4'b1011, 4'b0100, 4'b0000, 1'b0, 2'd2});
    vt.push_back('{1'b0, 4'b1011,  1, 4'b1011, 4'b0000, 4'b0000, 1'b0, 2'd2});
    vt.push_back('{1'b0, 4'b0010,  3, 4'b1011, 4'b0000, 4'b0000, 1'b1, 2'd3});
    vt.push_back('{1'b0, 4'b0010, 26, 4'b0011, 4'b1000, 4'b0000, 1'b0, 2'd3});
    vt.push_back('{1'b0, 4'b0010,  1, 4'b0011, 4'b0000, 4'b0000, 1'b1, 2'd0});
    vt.push_back('{1'b0, 4'b0010, 26, 4'b0010, 4'b0001, 4'b0000, 1'b0, 2'd0});
    // short glitch on key 1: abandon one edge after the mismatch clears
    vt.push_back('{1'b1, 4'b1101,  3, 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd1});
    vt.push_back('{1'b0, 4'b1111,  2, 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd1});
    vt.push_back('{1'b0, 4'b1111,  1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd1});

    do_reset();
    #1;
    chk("rst_state",   32'(key_state),   32'h0000000f);
    chk("rst_flag",    32'(key_flag),    32'h0);
    chk("rst_release", 32'(key_release), 32'h0);
    chk("rst_busy",    32'(busy),        32'h0);
    chk("rst_grant",   32'(grant_idx),   32'h0);

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].do_rst) begin
        do_reset();
      end else begin
        @(negedge sys_clk);
      end
      key_in = vt[i].key;
      repeat (vt[i].edges) @(posedge sys_clk);
      #1;
      chk($sformatf("v%0d_state", i),   32'(key_state),   32'(vt[i].st));
      chk($sformatf("v%0d_flag", i),    32'(key_flag),    32'(vt[i].fl));
      chk($sformatf("v%0d_release", i), 32'(key_release), 32'(vt[i].rl));
      chk($sformatf("v%0d_busy", i),    32'(busy),        32'(vt[i].bz));
      chk($sformatf("v%0d_grant", i),   32'(grant_idx),   32'(vt[i].gr));
    end

    // random bounce on key 1 for 10 cycles, then back to released
    do_reset();
    pulse_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      key_in = {2'b11, 1'($urandom_range(0, 1)), 1'b1};
    end
    @(negedge sys_clk);
    key_in = 4'b1111;
    repeat (6) @(posedge sys_clk);
    #1;
    chk("bounce_state", 32'(key_state), 32'h0000000f);
    chk("bounce_busy",  32'(busy),      32'h0);
    chk("bounce_pulses", 32'(pulse_cnt), 32'h0);

    // reset after 10 settle cycles on key 1, key kept held through reset
    do_reset();
    pulse_cnt = 0;
    key_in = 4'b1101;
    repeat (13) @(posedge sys_clk);
    #1;
    chk("midsettle_busy",  32'(busy),      32'h1);
    chk("midsettle_grant", 32'(grant_idx), 32'h1);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("async_rst_state", 32'(key_state), 32'h0000000f);
    chk("async_rst_flag",  32'(key_flag),  32'h0);
    chk("async_rst_busy",  32'(busy),      32'h0);
    chk("async_rst_grant", 32'(grant_idx), 32'h0);
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (28) @(posedge sys_clk);
    #1;
    chk("post_rst_noflag",  32'(key_flag),  32'h0);
    chk("post_rst_busy",    32'(busy),      32'h1);
    chk("post_rst_pulses",  32'(pulse_cnt), 32'h0);
    @(posedge sys_clk);
    #1;
    chk("post_rst_flag",  32'(key_flag),  32'h00000002);
    chk("post_rst_state", 32'(key_state), 32'h0000000d);
    @(posedge sys_clk);
    #1;
    chk("post_rst_flag_end", 32'(key_flag), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_scan_arbiter.md
# key_scan_arbiter

Shares one debounce counter between `KEY_NUM` active-low push-button inputs by round-robin scheduling. It sits between the raw board keys and the application logic, replacing one counter per key. Each key is synchronised, then granted the counter in turn when its level differs from its debounced state. After the change has stayed stable for `CNT_MAX+1` cycles, the block commits the new level and emits a one-cycle press flag.

## Interface
- `KEY_NUM`, 4: number of keys, 1..16.
- `CNT_MAX`, 20'd999_999: settle count; the stable window is CNT_MAX+1 cycles (20 ms at 50 MHz).
- `CNT_W`, 20: counter width; CNT_MAX must fit in it.
- `sys_clk`  in  1  system clock; all logic on the rising edge.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `key_in`  in  KEY_NUM  raw key levels, active low (0 = pressed).
- `key_state`  out  KEY_NUM  debounced levels; reset all 1.
- `key_flag`  out  KEY_NUM  one-cycle press pulse (1→0 commit); reset 0.
- `key_release`  out  KEY_NUM  one-cycle release pulse (0→1 commit); reset 0; see Configuration.
- `grant_idx`  out  $clog2(KEY_NUM) (min 1)  key currently owning the counter; reset 0.
- `busy`  out  1  high when state ≠ IDLE; reset 0.

## Operation
- Each `key_in` bit passes through a 2-flop synchroniser; both flops reset to 1. The synchronised vector is `ks`.
- Mismatch vector: `m = ks ^ key_state`.
- Round-robin pointer `ptr` resets to 0. Search order is ptr, ptr+1, …, KEY_NUM-1, 0, …, ptr-1.
- FSM states, reset = IDLE:
  - IDLE: if m≠0, set `grant_idx` to the first set bit of m in search order, clear `cnt` to 0, and go to SETTLE. Otherwise stay in IDLE.
  - SETTLE:
    - if m[grant_idx]=0, the input bounced back: set ptr = grant_idx+1 (wrapping) and go to IDLE, with no flag.
    - else if cnt==CNT_MAX, go to COMMIT.
    - else cnt = cnt+1.
  - COMMIT: invert key_state[grant_idx] and pulse the matching flag. Set ptr = grant_idx+1, wrapping KEY_NUM-1→0. Go to IDLE.
- Mismatches on non-granted keys are ignored while SETTLE is in progress. They stay pending and are served later.
- Starvation bound: a pending key is granted within KEY_NUM-1 other grants.
- `key_flag` and `key_release` are registered. At most one bit across both vectors is high in any cycle.
- `cnt` never exceeds CNT_MAX and never wraps.
- CNT_MAX=0 is legal and gives a 1-cycle settle window.
- Asserting `sys_rst` at any time, including mid-SETTLE, immediately forces every register to its reset value. An aborted settle produces no flag.

## Timing
- Let E0 be the first clock edge at which a new key_in level is sampled.
- Uncontended press: `key_state` changes and `key_flag` goes high after edge E(CNT_MAX+4), and the flag stays high for exactly one cycle.
  - E1: the level appears in ks.
  - E2: the key is granted.
  - E(CNT_MAX+3): the FSM enters COMMIT.
- Back-to-back grants: a pending key's flag follows the previous commit flag by exactly CNT_MAX+3 cycles.
- `busy` rises after the granting edge. It falls after the edge on which COMMIT or an abandon returns the FSM to IDLE.
- Bounce abandon: the FSM returns to IDLE one edge after m[grant_idx] is seen low. A re-grant can occur on the following edge.

## Configuration
- `KEY_RELEASE_FLAG_EN` defined: a 0→1 commit pulses `key_release[grant_idx]` for one cycle.
- Macro undefined:
  - `key_release` is tied to 0.
  - Releases are still debounced and still update `key_state` through the same FSM path, but emit no pulse.
  - `key_flag` behaviour is identical in both builds.

## Test plan
- All tests use KEY_NUM=4 and CNT_MAX=24 at 50 MHz.
- Clean press: key_in[0] 1→0 and held → key_flag=4'b0001 for one cycle, 28 edges after the change is first sampled. key_state=4'b1110 thereafter.
- Bounce: key_in[1] toggles randomly for 10 cycles, then returns to 1 → no flag, key_state stays 4'b1111, and busy returns to 0.
- Simultaneous press: key_in[0] and key_in[2] fall on the same cycle → key_flag[0] first, then key_flag[2] exactly 27 cycles later, with grant_idx going 0 then 2.
- Fairness and wrap: release ptr at 3, then press keys 0 and 3 together → key 3 is granted first, then key 0 (pointer wraps).
- Release: hold key 0 pressed, then release it.
  - With KEY_RELEASE_FLAG_EN: key_release=4'b0001 for one cycle, 28 edges after release.
  - Without the macro: key_release stays 0 and key_state[0] returns to 1.
- Reset mid-settle: assert sys_rst after 10 SETTLE cycles → all outputs go to reset values immediately. Releasing reset with the key still held gives the flag 28 edges after reset release.
